ones_frame_accumulator: RTL
===========================

// Module: ones_frame_accumulator
// PURPOSE
//  - Sits directly downstream of the combinational 7-input ones counter. It takes a stream of
//    7-bit words and sums their ones-counts over a frame.
//  - A frame ends on in_last, or when MAX_WORDS words have been accepted.
//  - It then presents the frame total and the word count on a valid/ready output, holding both
//    until the consumer takes them.
// PARAMETERS
//  - ACC_W      8   width of the ones-total accumulator (wraps or saturates; see BEHAVIOUR)
//  - MAX_WORDS  16  forced frame length limit, >=1
//  - CNT_W      localparam = $clog2(MAX_WORDS+1); width of the word counter
// PORTS
//  - clk        in   1      single clock, rising edge
//  - rst        in   1      asynchronous, active-high reset
//  - in_word    in   7      data word whose ones are counted
//  - in_valid   in   1      in_word/in_last valid
//  - in_last    in   1      final word of the frame
//  - in_ready   out  1      block can accept a word this cycle
//  - out_count  out  ACC_W  total ones in the frame
//  - out_words  out  CNT_W  number of words accepted in the frame
//  - out_sat    out  1      accumulator saturated this frame (only with ACC_SATURATE_EN, else 0)
//  - out_valid  out  1      result valid, held until accepted
//  - out_ready  in   1      consumer takes the result
//  - busy       out  1      frame in progress (state ACCUM)
// BEHAVIOUR
//  - FSM states: IDLE -> ACCUM -> HOLD -> IDLE.
//  - Reset (async, active-high): state=IDLE, acc=0, words=0, sat=0, out_valid=0, busy=0.
//  - Handshakes: in_ready = (state != HOLD). Accept = in_valid & in_ready.
//    Output handshake = out_valid & out_ready.
//  - On accept: acc <= acc + zero-extended popcount(in_word) (0..7); words <= words+1.
//  - IDLE: accept -> ACCUM, unless the word closes the frame, in which case -> HOLD directly.
//  - Frame close: accept with in_last=1, or accept of word number MAX_WORDS.
//    - Next state HOLD; the registered sum includes the closing word.
//  - Latency: out_valid rises on the cycle after the closing word is accepted.
//  - HOLD: out_valid=1, in_ready=0. out_count/out_words/out_sat are stable until handshake;
//    in_valid is ignored.
//  - Handshake in HOLD: acc, words and sat clear; state -> IDLE.
//    - in_ready returns the next cycle; there is no same-cycle bypass.
//  - out_count/out_words show the live acc/words at all times. They are only meaningful while
//    out_valid=1.
//  - in_last on a non-accepted cycle has no effect.
//  - MAX_WORDS=1: every accepted word closes a frame.
//  - Reset mid-frame or mid-HOLD: partial frame and pending result are discarded.
//    No out_valid is produced for them.
// CONFIGURATION
//  - Macro ACC_SATURATE_EN.
//  - Defined: acc + popcount clamps at 2^ACC_W-1. out_sat sets sticky for the frame and clears
//    with the accumulator.
//  - Undefined: the sum wraps modulo 2^ACC_W and out_sat is tied 0.
//  - Port list is identical in both builds.
// STRUCTURE
//  - Package ones_acc_pkg:
//    - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} ones_acc_state_t
//    - localparam WORD_W=7, POP_W=3
//  - Sub-module ones_count7: purely combinational popcount of 7 bits -> 3 bits, instantiated
//    once on in_word.
//  - All registers live in this module: state, acc, words, sat.
// TESTING
//  - Single frame: words 7'h7F, 7'h01, 7'h00(last) -> out_count=8, out_words=3.
//    out_valid high the cycle after the last accept.
//  - Forced close: 16 words of 7'h03, no in_last -> out_count=32, out_words=16.
//    in_ready=0 from the cycle after the 16th accept until the handshake.
//  - Back-pressure: out_ready=0 for 5 cycles in HOLD.
//    -> outputs stable, in_valid ignored; handshake on cycle 6, then IDLE and in_ready=1.
//  - Overflow, ACC_W=4: 3 words of 7'h7F (21 ones).
//    -> out_count=5 (wrap) without the macro; out_count=15, out_sat=1 with ACC_SATURATE_EN.
//  - Reset mid-frame after 2 words: acc=0, state IDLE.
//    A following single word 7'h0F(last) yields out_count=4, out_words=1.
//  - Random stream vs. reference model: 1000 frames, random in_valid/out_ready gaps.
//    Each total equals the software popcount sum.

Source files
------------

// File: rtl/ones_acc_pkg.sv
// Shared types and widths for the ones frame accumulator.
package ones_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} ones_acc_state_t;

    localparam int WORD_W = 7;
    localparam int POP_W  = 3;

endpackage

// File: rtl/ones_count7.sv
// Combinational population count of one 7-bit word (0..7).
module ones_count7
    import ones_acc_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [POP_W-1:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WORD_W; i++) begin
            o_count = o_count + POP_W'(i_word[i]);
        end
    end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Sums popcounts of 7-bit words over a frame (closed by in_last or MAX_WORDS) and holds the
// result on a valid/ready output. Define ACC_SATURATE_EN to clamp the sum instead of wrapping.
module ones_frame_accumulator
    import ones_acc_pkg::*;
#(
    parameter  int ACC_W     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic [CNT_W-1:0]  out_words,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    ones_acc_state_t  r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_words;
    logic             r_out_valid;
    logic             r_busy;

    logic [POP_W-1:0] w_pop;
    logic             w_accept;
    logic             w_close;
    logic             w_out_hs;
    logic [ACC_W-1:0] w_acc_next;

    ones_count7 u_count (
        .i_word  (in_word),
        .o_count (w_pop)
    );

    // Input side is open in every state except HOLD, which is exactly when out_valid is set.
    assign in_ready  = ~r_out_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_close   = in_last | (r_words == CNT_W'(MAX_WORDS - 1));
    assign w_out_hs  = r_out_valid & out_ready;

    assign out_count = r_acc;
    assign out_words = r_words;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] w_sum;
    logic           r_sat;

    // The extra carry bit detects overflow; clamp to all-ones and flag it for the frame.
    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(w_pop);
    assign w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign out_sat    = r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_out_hs) begin
            r_sat <= 1'b0;
        end else if (w_accept && w_sum[ACC_W]) begin
            r_sat <= 1'b1;
        end
    end
`else
    assign w_acc_next = r_acc + ACC_W'(w_pop);
    assign out_sat    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_words     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_words <= r_words + CNT_W'(1);
                        if (w_close) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_words     <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
